// File: rtl/order_arbiter.sv
// Round-robin order arbiter feeding one matching engine, with a settle window after each issue.
// Define ARB_FIXED_PRIO_EN to select fixed lowest-index-wins priority instead of round-robin.
module order_arbiter #(
  parameter int N_REQ    = 4,
  parameter int PRICE_W  = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*PRICE_W-1:0]     req_buy,
  input  logic [N_REQ*PRICE_W-1:0]     req_sell,
  input  logic                         halt_signal,
  output logic [N_REQ-1:0]             req_ready,
  output logic [PRICE_W-1:0]           buy_price,
  output logic [PRICE_W-1:0]           sell_price,
  output logic                         order_valid,
  output logic [$clog2(N_REQ)-1:0]     grant_id,
  output logic                         busy,
  output logic [7:0]                   issue_count
);

  localparam int         ID_W      = $clog2(N_REQ);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ID_W-1:0]      r_last_ptr;
  logic [ID_W-1:0]      r_grant_id;
  logic [PRICE_W-1:0]   r_buy;
  logic [PRICE_W-1:0]   r_sell;
  logic [3:0]           r_hold;
  logic [7:0]           r_count;

  logic                 w_found;
  logic [ID_W-1:0]      w_winner;
  logic [ID_W-1:0]      w_idx;
  logic                 w_accept;
  logic [PRICE_W-1:0]   w_sel_buy;
  logic [PRICE_W-1:0]   w_sel_sell;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(i);
      end
    end
`else
    // Search starts one past the last winner and wraps, so the last winner has lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = ID_W'((int'(r_last_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
`endif
  end

  assign w_sel_buy  = req_buy[int'(w_winner)*PRICE_W +: PRICE_W];
  assign w_sel_sell = req_sell[int'(w_winner)*PRICE_W +: PRICE_W];

  // Halt wins over any pending request, and nothing is accepted while reset is high.
  assign w_accept  = (r_state == S_IDLE) && !reset && !halt_signal && w_found;
  assign req_ready = w_accept ? (N_REQ'(1) << w_winner) : '0;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (halt_signal)  w_state_nxt = S_HALTED;
        else if (w_found) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_hold == 4'd0) w_state_nxt = halt_signal ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (!halt_signal) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last_ptr <= ID_W'(N_REQ - 1);
      r_grant_id <= '0;
      r_buy      <= '0;
      r_sell     <= '0;
      r_hold     <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_buy      <= w_sel_buy;
        r_sell     <= w_sel_sell;
        r_grant_id <= w_winner;
        r_last_ptr <= w_winner;
      end
      if (r_state == S_ISSUE) begin
        r_hold <= HOLD_LOAD;
        if (r_count != 8'hFF) r_count <= r_count + 8'd1;
      end else if (r_state == S_WAIT && r_hold != 4'd0) begin
        r_hold <= r_hold - 4'd1;
      end
    end
  end

  assign buy_price   = r_buy;
  assign sell_price  = r_sell;
  assign grant_id    = r_grant_id;
  assign issue_count = r_count;
  assign order_valid = (r_state == S_ISSUE);
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_order_arbiter.sv
// Self-checking bench for order_arbiter: directed vector table, hand sequences and a randomized run
// checked against a transaction-timing reference model.
module tb_order_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_buy;
  logic [N*W-1:0]   req_sell;
  logic             halt_signal;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     buy_price;
  logic [W-1:0]     sell_price;
  logic             order_valid;
  logic [1:0]       grant_id;
  logic             busy;
  logic [7:0]       issue_count;

  order_arbiter #(.N_REQ(N), .PRICE_W(W), .HOLD_CYC(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_buy     (req_buy),
    .req_sell    (req_sell),
    .halt_signal (halt_signal),
    .req_ready   (req_ready),
    .buy_price   (buy_price),
    .sell_price  (sell_price),
    .order_valid (order_valid),
    .grant_id    (grant_id),
    .busy        (busy),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the engine is owned for HOLD+2 cycles per accepted order (m_left counts
  // the cycles still owed after the accept cycle); a halt seen while free or at the last owed
  // cycle parks the arbiter until halt drops.
  int         m_left;
  bit         m_halted;
  int         m_last;
  logic [7:0] m_buy, m_sell;
  int         m_gid;
  int         m_cnt;
  logic [N-1:0] s_ready;

  task automatic model_reset();
    m_left = 0; m_halted = 0; m_last = N - 1;
    m_buy = 0; m_sell = 0; m_gid = 0; m_cnt = 0;
  endtask

  function automatic int pick(input logic [N-1:0] v);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
`endif
    return -1;
  endfunction

  // Entered just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [N-1:0] v, input logic h, input logic r,
                      input logic [N*W-1:0] b, input logic [N*W-1:0] s);
    int win;
    logic [N-1:0] exp_ready;
    req_valid = v; halt_signal = h; reset = r; req_buy = b; req_sell = s;
    #1;
    win = -1;
    exp_ready = '0;
    if (!r && m_left == 0 && !m_halted && !h) win = pick(v);
    if (win >= 0) exp_ready[win] = 1'b1;
    s_ready = req_ready;
    check("req_ready",   32'(req_ready),   32'(exp_ready));
    check("order_valid", 32'(order_valid), 32'(m_left == HOLD + 1));
    check("busy",        32'(busy),        32'(m_left != 0 || m_halted));
    check("buy_price",   32'(buy_price),   32'(m_buy));
    check("sell_price",  32'(sell_price),  32'(m_sell));
    check("grant_id",    32'(grant_id),    32'(m_gid));
    check("issue_count", 32'(issue_count), 32'(m_cnt));
    @(posedge clk);
    if (r) model_reset();
    else if (m_left > 0) begin
      if (m_left == HOLD + 1 && m_cnt < 255) m_cnt++;
      if (m_left == 1 && h) m_halted = 1;
      m_left--;
    end else if (m_halted) begin
      if (!h) m_halted = 0;
    end else if (h) m_halted = 1;
    else if (win >= 0) begin
      m_buy  = b[win*W +: W];
      m_sell = s[win*W +: W];
      m_gid  = win;
      m_last = win;
      m_left = HOLD + 1;
    end
    @(negedge clk);
  endtask

  task automatic hard_reset();
    reset = 1'b1; req_valid = '0; halt_signal = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         halt;
    logic [N-1:0] ready;
    logic         ov;
    logic         busy;
    int           gid;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int g1, g2;
    int grants, r3_seen;
`ifdef ARB_FIXED_PRIO_EN
    g1 = 0; g2 = 0;
`else
    g1 = 1; g2 = 2;
`endif
    tbl[0]  = '{4'hF, 1'b0, 4'b0001,         1'b0, 1'b0, 0};
    tbl[1]  = '{4'hF, 1'b0, 4'b0000,         1'b1, 1'b1, 0};
    tbl[2]  = '{4'hF, 1'b0, 4'b0000,         1'b0, 1'b1, 0};
    tbl[3]  = '{4'hF, 1'b0, 4'b0000,         1'b0, 1'b1, 0};
    tbl[4]  = '{4'hF, 1'b0, 4'b0001 << g1,   1'b0, 1'b0, 0};
    tbl[5]  = '{4'h0, 1'b0, 4'b0000,         1'b1, 1'b1, g1};
    tbl[6]  = '{4'h0, 1'b1, 4'b0000,         1'b0, 1'b1, g1};
    tbl[7]  = '{4'h0, 1'b1, 4'b0000,         1'b0, 1'b1, g1};
    tbl[8]  = '{4'hF, 1'b1, 4'b0000,         1'b0, 1'b1, g1};
    tbl[9]  = '{4'hF, 1'b0, 4'b0000,         1'b0, 1'b1, g1};
    tbl[10] = '{4'hF, 1'b0, 4'b0001 << g2,   1'b0, 1'b0, g1};
    tbl[11] = '{4'h0, 1'b0, 4'b0000,         1'b1, 1'b1, g2};
    tbl[12] = '{4'h0, 1'b0, 4'b0000,         1'b0, 1'b1, g2};
    tbl[13] = '{4'h0, 1'b0, 4'b0000,         1'b0, 1'b1, g2};
    tbl[14] = '{4'hF, 1'b1, 4'b0000,         1'b0, 1'b0, g2};
    tbl[15] = '{4'hF, 1'b0, 4'b0000,         1'b0, 1'b1, g2};
    tbl[16] = '{4'h8, 1'b0, 4'b1000,         1'b0, 1'b0, g2};
    tbl[17] = '{4'h0, 1'b0, 4'b0000,         1'b1, 1'b1, 3};

    // Reset state, and no ready while reset is high even with every request valid.
    reset = 1'b1; req_valid = '0; halt_signal = 1'b0;
    req_buy  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_sell = {8'h23, 8'h22, 8'h21, 8'h20};
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    check("rst_ready",   32'(req_ready),   32'h0);
    check("rst_ov",      32'(order_valid), 32'h0);
    check("rst_busy",    32'(busy),        32'h0);
    check("rst_buy",     32'(buy_price),   32'h0);
    check("rst_sell",    32'(sell_price),  32'h0);
    check("rst_gid",     32'(grant_id),    32'h0);
    check("rst_count",   32'(issue_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: round-robin order, halt during WAIT, halt wins in IDLE, pointer wrap.
    for (int i = 0; i < 18; i++) begin
      req_valid = tbl[i].valid; halt_signal = tbl[i].halt;
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(req_ready),   32'(tbl[i].ready));
      check($sformatf("tbl%0d_ov", i),    32'(order_valid), 32'(tbl[i].ov));
      check($sformatf("tbl%0d_busy", i),  32'(busy),        32'(tbl[i].busy));
      check($sformatf("tbl%0d_gid", i),   32'(grant_id),    32'(tbl[i].gid));
      if (tbl[i].ov) begin
        check($sformatf("tbl%0d_buy", i),  32'(buy_price),  32'h10 + 32'(tbl[i].gid));
        check($sformatf("tbl%0d_sell", i), 32'(sell_price), 32'h20 + 32'(tbl[i].gid));
      end
      @(negedge clk);
    end

    // Single requester 2 with buy 0x40 / sell 0x3C.
    hard_reset();
    step(4'b0100, 1'b0, 1'b0, 32'h00400000, 32'h003C0000);
    check("single_ov",   32'(order_valid), 32'h1);
    check("single_buy",  32'(buy_price),   32'h40);
    check("single_sell", 32'(sell_price),  32'h3C);
    check("single_gid",  32'(grant_id),    32'h2);
    for (int i = 0; i < 3; i++) begin
      check("single_busy", 32'(busy), 32'h1);
      step(4'b0000, 1'b0, 1'b0, 32'h00400000, 32'h003C0000);
    end
    check("single_idle", 32'(busy), 32'h0);

    // Reset during WAIT abandons the order and restores requester 0 priority.
    step(4'hF, 1'b0, 1'b0, 32'hA1B2C3D4, 32'h11223344);
    step(4'hF, 1'b0, 1'b0, 32'hA1B2C3D4, 32'h11223344);
    step(4'hF, 1'b0, 1'b1, 32'hA1B2C3D4, 32'h11223344);
    check("rw_ov",    32'(order_valid), 32'h0);
    check("rw_busy",  32'(busy),        32'h0);
    check("rw_buy",   32'(buy_price),   32'h0);
    check("rw_gid",   32'(grant_id),    32'h0);
    check("rw_count", 32'(issue_count), 32'h0);
    req_valid = 4'hF; halt_signal = 1'b0; reset = 1'b0;
    #1;
    check("rw_next_ready", 32'(req_ready), 32'h1);
    step(4'hF, 1'b0, 1'b0, 32'hA1B2C3D4, 32'h11223344);

    // Randomized traffic with occasional halts and resets.
    hard_reset();
    for (int i = 0; i < 400; i++)
      step(N'($urandom), ($urandom_range(7) == 0), ($urandom_range(63) == 0), $urandom, $urandom);

    // Saturation: 300 orders back to back.
    hard_reset();
    for (int i = 0; i < 300 * (HOLD + 2); i++)
      step(4'hF, 1'b0, 1'b0, $urandom, $urandom);
    check("sat_count", 32'(issue_count), 32'd255);

`ifdef ARB_FIXED_PRIO_EN
    hard_reset();
    grants = 0; r3_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'b1001, 1'b0, 1'b0, $urandom, $urandom);
      if (s_ready[0]) grants++;
      if (s_ready[3]) r3_seen++;
    end
    check("fp_grants0", 32'(grants),  32'd10);
    check("fp_ready3",  32'(r3_seen), 32'd0);
`else
    grants = 0; r3_seen = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
